sysad_ext_ctl: RTL and testbench

- External-agent (RCP-side) controller for the VR4300 SysAD bus.
- Accepts CPU single and block read/write requests, paces them with eok_l, and collects write data into an 8-word buffer.
- Issues one request per transaction to a memory/IO backend, then returns read response words to the CPU with evalid_l.
- Owns SysAD drive direction (sysad_oe) and the bus turnaround; the top level builds the tristate from it.

---
 rtl/sysad_ext_ctl.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_sysad_ext_ctl.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysad_ext_ctl.sv
// sysad_ext_ctl -- external-agent (RCP side) controller for the VR4300 SysAD bus.
//
// Accepts single and block read/write requests from the CPU, paces them with
// eok_l, gathers write data into an 8-word buffer, issues one backend request
// per transaction and returns read words to the CPU with evalid_l. The
// controller owns SysAD drive direction (sysad_oe); the tristate is built above.
//
// Ports
//   sysclk, reset_l          clock (rising edge) / asynchronous active-low reset
//   sysad_in, syscmd_in,     CPU-driven SysAD / SysCmd and address/data valid
//   pvalid_l
//   sysad_out, syscmd_out    read response data / command, sysad_oe enables drive
//   eok_l, evalid_l, ereq_l  external agent ready / data valid / request (held 1)
//   mem_req/we/addr/size/blk backend request, held until mem_ack
//   mem_wdata, mem_wvalid    write data stream to backend
//   mem_rdata/rvalid/rerr    read data stream from backend
//   cmd_err                  one-cycle pulse on any protocol error
module sysad_ext_ctl #(
  parameter int RSP_TIMEOUT = 64,
  parameter int WR_TIMEOUT  = 16
) (
  input  logic        sysclk,
  input  logic        reset_l,
  input  logic [31:0] sysad_in,
  input  logic [4:0]  syscmd_in,
  input  logic        pvalid_l,
  output logic [31:0] sysad_out,
  output logic [4:0]  syscmd_out,
  output logic        sysad_oe,
  output logic        eok_l,
  output logic        evalid_l,
  output logic        ereq_l,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic        mem_blk,
  input  logic        mem_ack,
  output logic [31:0] mem_wdata,
  output logic        mem_wvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        mem_rerr,
  output logic        cmd_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WDATA   = 3'd1;
  localparam logic [2:0] S_WMEM    = 3'd2;
  localparam logic [2:0] S_WSTREAM = 3'd3;
  localparam logic [2:0] S_RMEM    = 3'd4;
  localparam logic [2:0] S_RTURN   = 3'd5;
  localparam logic [2:0] S_RRSP    = 3'd6;

  localparam int TMAX = (RSP_TIMEOUT > WR_TIMEOUT) ? RSP_TIMEOUT : WR_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;        // words captured / streamed / returned
  logic [3:0]    nwords_q, nwords_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;        // sticky read error for this transaction
  logic          fill_q, fill_d;      // read timed out, error-filling the rest

  logic          eok_l_q, eok_l_d;
  logic          evalid_l_q, evalid_l_d;
  logic          sysad_oe_q, sysad_oe_d;
  logic [4:0]    syscmd_out_q, syscmd_out_d;
  logic [31:0]   sysad_out_q, sysad_out_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [1:0]    mem_size_q, mem_size_d;
  logic          mem_blk_q, mem_blk_d;
  logic          mem_wvalid_q, mem_wvalid_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          cmd_err_q, cmd_err_d;

  logic [31:0]   buf_q [8];
  logic          buf_we;

  logic          pv_addr, pv_data;
  logic [3:0]    last_idx;
  logic [TW-1:0] timer_inc;
  logic          is_last;
  logic          emit;
  logic [31:0]   emit_data;
  logic          emit_err;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nwords_d     = nwords_q;
    timer_d      = timer_q;
    err_d        = err_q;
    fill_d       = fill_q;
    eok_l_d      = 1'b1;
    evalid_l_d   = 1'b1;
    sysad_oe_d   = sysad_oe_q;
    syscmd_out_d = syscmd_out_q;
    sysad_out_d  = sysad_out_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_size_d   = mem_size_q;
    mem_blk_d    = mem_blk_q;
    mem_wvalid_d = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    cmd_err_d    = 1'b0;
    buf_we       = 1'b0;
    emit         = 1'b0;
    emit_data    = '0;
    emit_err     = 1'b0;

    pv_addr   = !pvalid_l && !syscmd_in[4];
    pv_data   = !pvalid_l &&  syscmd_in[4];
    last_idx  = nwords_q - 4'd1;
    timer_inc = timer_q + TW'(1);
    is_last   = (cnt_q == last_idx);

    // Read data with no read response in progress is dropped and flagged.
    if (mem_rvalid && state_q != S_RRSP) cmd_err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        eok_l_d = 1'b0;
        if (pv_data) begin
          cmd_err_d = 1'b1;
        end else if (pv_addr && !eok_l_q) begin
          if (syscmd_in[2] && syscmd_in[1:0] == 2'b11) begin
            cmd_err_d = 1'b1;
          end else begin
            eok_l_d    = 1'b1;
            mem_addr_d = sysad_in;
            mem_size_d = syscmd_in[1:0];
            mem_blk_d  = syscmd_in[2];
            mem_we_d   = syscmd_in[3];
            if (!syscmd_in[2]) begin
              nwords_d = 4'd1;
            end else begin
              case (syscmd_in[1:0])
                2'b00:   nwords_d = 4'd2;
                2'b01:   nwords_d = 4'd4;
                default: nwords_d = 4'd8;
              endcase
            end
            cnt_d   = '0;
            timer_d = '0;
            err_d   = 1'b0;
            fill_d  = 1'b0;
            if (syscmd_in[3]) begin
              state_d = S_WDATA;
            end else begin
              state_d   = S_RMEM;
              mem_req_d = 1'b1;
            end
          end
        end
      end

      S_WDATA: begin
        if (pv_addr) begin
          // A new address while write data is owed aborts the write.
          cmd_err_d = 1'b1;
          state_d   = S_IDLE;
        end else if (pv_data) begin
          timer_d = '0;
          // syscmd_in[3] is the "more data" marker: it must be clear exactly
          // on word N-1, so a marker equal to is_last is a framing error.
          if (syscmd_in[3] == is_last) begin
            cmd_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            buf_we = 1'b1;
            cnt_d  = cnt_q + 4'd1;
            if (is_last) begin
              state_d   = S_WMEM;
              mem_req_d = 1'b1;
            end
          end
        end else if (timer_inc == TW'(WR_TIMEOUT)) begin
          cmd_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end

      S_WMEM: begin
        if (mem_ack) begin
          // First word goes out on the acknowledge edge itself.
          mem_req_d    = 1'b0;
          mem_wvalid_d = 1'b1;
          mem_wdata_d  = buf_q[0];
          cnt_d        = 4'd1;
          state_d      = (nwords_q == 4'd1) ? S_IDLE : S_WSTREAM;
        end
      end

      S_WSTREAM: begin
        mem_wvalid_d = 1'b1;
        mem_wdata_d  = buf_q[cnt_q[2:0]];
        cnt_d        = cnt_q + 4'd1;
        if (is_last) state_d = S_IDLE;
      end

      S_RMEM: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_RTURN;
        end
      end

      S_RTURN: begin
        // One dead cycle with SysAD undriven so the CPU can release the bus.
        sysad_oe_d = 1'b1;
        cnt_d      = '0;
        timer_d    = '0;
        state_d    = S_RRSP;
      end

      S_RRSP: begin
        if (cnt_q == nwords_q) begin
          // Final word is on the bus this cycle; release and return to idle.
          if (mem_rvalid || fill_q) cmd_err_d = 1'b1;
          sysad_oe_d = 1'b0;
          state_d    = S_IDLE;
        end else if (fill_q) begin
          if (mem_rvalid) cmd_err_d = 1'b1;
          emit     = 1'b1;
          emit_err = 1'b1;
        end else if (mem_rvalid) begin
          emit      = 1'b1;
          emit_data = mem_rdata;
          emit_err  = err_q | mem_rerr;
          timer_d   = '0;
        end else if (timer_inc == TW'(RSP_TIMEOUT)) begin
          fill_d   = 1'b1;
          emit     = 1'b1;
          emit_err = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      evalid_l_d   = 1'b0;
      sysad_out_d  = emit_data;
      err_d        = emit_err;
      syscmd_out_d = {1'b1, (cnt_q != last_idx), 1'b0, emit_err, 1'b0};
      cnt_d        = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge sysclk or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      nwords_q     <= '0;
      timer_q      <= '0;
      err_q        <= 1'b0;
      fill_q       <= 1'b0;
      eok_l_q      <= 1'b1;
      evalid_l_q   <= 1'b1;
      sysad_oe_q   <= 1'b0;
      syscmd_out_q <= '0;
      sysad_out_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_size_q   <= '0;
      mem_blk_q    <= 1'b0;
      mem_wvalid_q <= 1'b0;
      mem_wdata_q  <= '0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nwords_q     <= nwords_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      fill_q       <= fill_d;
      eok_l_q      <= eok_l_d;
      evalid_l_q   <= evalid_l_d;
      sysad_oe_q   <= sysad_oe_d;
      syscmd_out_q <= syscmd_out_d;
      sysad_out_q  <= sysad_out_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_size_q   <= mem_size_d;
      mem_blk_q    <= mem_blk_d;
      mem_wvalid_q <= mem_wvalid_d;
      mem_wdata_q  <= mem_wdata_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  // Write buffer contents are only meaningful below cnt_q, so no reset needed.
  always_ff @(posedge sysclk) begin
    if (buf_we) buf_q[cnt_q[2:0]] <= sysad_in;
  end

  assign sysad_out  = sysad_out_q;
  assign syscmd_out = syscmd_out_q;
  assign sysad_oe   = sysad_oe_q;
  assign eok_l      = eok_l_q;
  assign evalid_l   = evalid_l_q;
  assign ereq_l     = 1'b1;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_size   = mem_size_q;
  assign mem_blk    = mem_blk_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wvalid = mem_wvalid_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_sysad_ext_ctl.sv
module tb_sysad_ext_ctl;

  logic        sysclk = 1'b0;
  logic        reset_l;
  logic [31:0] sysad_in;
  logic [4:0]  syscmd_in;
  logic        pvalid_l;
  logic [31:0] sysad_out;
  logic [4:0]  syscmd_out;
  logic        sysad_oe;
  logic        eok_l;
  logic        evalid_l;
  logic        ereq_l;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_blk;
  logic        mem_ack;
  logic [31:0] mem_wdata;
  logic        mem_wvalid;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_rerr;
  logic        cmd_err;

  int vectors     = 0;
  int miscompares = 0;
  int err_cnt     = 0;

  sysad_ext_ctl dut (
    .sysclk     (sysclk),
    .reset_l    (reset_l),
    .sysad_in   (sysad_in),
    .syscmd_in  (syscmd_in),
    .pvalid_l   (pvalid_l),
    .sysad_out  (sysad_out),
    .syscmd_out (syscmd_out),
    .sysad_oe   (sysad_oe),
    .eok_l      (eok_l),
    .evalid_l   (evalid_l),
    .ereq_l     (ereq_l),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_size   (mem_size),
    .mem_blk    (mem_blk),
    .mem_ack    (mem_ack),
    .mem_wdata  (mem_wdata),
    .mem_wvalid (mem_wvalid),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_rerr   (mem_rerr),
    .cmd_err    (cmd_err)
  );

  always #5 sysclk = ~sysclk;

  // Count cmd_err pulses so a test can check how many occurred over a window.
  always @(negedge sysclk) if (cmd_err === 1'b1) err_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic idle_inputs();
    pvalid_l   = 1'b1;
    syscmd_in  = '0;
    sysad_in   = '0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_rerr   = 1'b0;
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    idle_inputs();
    repeat (3) step();
    vectors++;
    if ({eok_l, evalid_l, ereq_l, sysad_oe, mem_req, mem_wvalid, cmd_err} !== 7'b1110000) begin
      miscompares++;
      $display("FAIL rst_ctl got %b exp 1110000", {eok_l, evalid_l, ereq_l, sysad_oe, mem_req, mem_wvalid, cmd_err});
    end
    vectors++;
    if ({syscmd_out, sysad_out} !== 37'h0) begin
      miscompares++;
      $display("FAIL rst_data got %h/%h exp 0/0", syscmd_out, sysad_out);
    end
    reset_l = 1'b1;
    step();
    vectors++;
    if (eok_l !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_release_eok got %b exp 0", eok_l);
    end
    $display("reset: done");
  endtask

  task automatic test_single_write();
    int e0 = err_cnt;
    pvalid_l = 1'b0; syscmd_in = 5'b01011; sysad_in = 32'h0440_0010;
    step();
    vectors++;
    if ({eok_l, mem_req} !== 2'b10) begin
      miscompares++;
      $display("FAIL sw_accept eok/req got %b exp 10", {eok_l, mem_req});
    end
    syscmd_in = 5'b10000; sysad_in = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    vectors++;
    if ({mem_req, mem_we, mem_blk, mem_size, mem_addr} !== {1'b1, 1'b1, 1'b0, 2'b11, 32'h0440_0010}) begin
      miscompares++;
      $display("FAIL sw_req got req=%b we=%b blk=%b size=%b addr=%h exp 1 1 0 11 04400010",
               mem_req, mem_we, mem_blk, mem_size, mem_addr);
    end
    step();
    step();
    vectors++;
    if ({mem_req, mem_wvalid} !== 2'b10) begin
      miscompares++;
      $display("FAIL sw_hold req/wvalid got %b exp 10", {mem_req, mem_wvalid});
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    vectors++;
    if ({mem_req, mem_wvalid, mem_wdata, eok_l} !== {1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1}) begin
      miscompares++;
      $display("FAIL sw_wdata got req=%b wv=%b wd=%h eok=%b exp 0 1 deadbeef 1",
               mem_req, mem_wvalid, mem_wdata, eok_l);
    end
    step();
    vectors++;
    if ({mem_wvalid, eok_l, err_cnt - e0} !== {1'b0, 1'b0, 32'd0}) begin
      miscompares++;
      $display("FAIL sw_done got wv=%b eok=%b errs=%0d exp 0 0 0", mem_wvalid, eok_l, err_cnt - e0);
    end
    $display("single write 04400010 <- deadbeef: done");
  endtask

  task automatic test_block_write();
    logic [31:0] wd [2];
    wd[0] = 32'hAAAA_0000;
    wd[1] = 32'hBBBB_1111;
    pvalid_l = 1'b0; syscmd_in = 5'b01100; sysad_in = 32'h0000_2000;
    step();
    for (int i = 0; i < 2; i++) begin
      syscmd_in = (i == 1) ? 5'b10000 : 5'b11000;
      sysad_in  = wd[i];
      step();
    end
    idle_inputs();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({mem_wvalid, mem_wdata} !== {1'b1, wd[i]}) begin
        miscompares++;
        $display("FAIL bw_word%0d got wv=%b wd=%h exp 1 %h", i, mem_wvalid, mem_wdata, wd[i]);
      end
      step();
    end
    vectors++;
    if ({mem_wvalid, eok_l} !== 2'b00) begin
      miscompares++;
      $display("FAIL bw_done wv/eok got %b exp 00", {mem_wvalid, eok_l});
    end
    $display("block write 2 words: done");
  endtask

  task automatic test_block_read8();
    int e0 = err_cnt;
    pvalid_l = 1'b0; syscmd_in = 5'b00110; sysad_in = 32'h0000_1000;
    step();
    idle_inputs();
    vectors++;
    if ({mem_req, mem_we, mem_blk, mem_size, eok_l} !== 6'b101101) begin
      miscompares++;
      $display("FAIL br8_req got %b exp 101101", {mem_req, mem_we, mem_blk, mem_size, eok_l});
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    vectors++;
    if ({mem_req, sysad_oe} !== 2'b00) begin
      miscompares++;
      $display("FAIL br8_turn req/oe got %b exp 00", {mem_req, sysad_oe});
    end
    step();
    vectors++;
    if ({sysad_oe, evalid_l} !== 2'b11) begin
      miscompares++;
      $display("FAIL br8_rrsp oe/evalid got %b exp 11", {sysad_oe, evalid_l});
    end
    for (int i = 0; i < 8; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'(i);
      step();
      vectors++;
      if ({sysad_oe, evalid_l, syscmd_out, sysad_out} !== {1'b1, 1'b0, (i < 7) ? 5'b11000 : 5'b10000, 32'(i)}) begin
        miscompares++;
        $display("FAIL br8_word%0d got oe=%b ev=%b cmd=%b d=%h exp 1 0 %b %h", i, sysad_oe, evalid_l,
                 syscmd_out, sysad_out, (i < 7) ? 5'b11000 : 5'b10000, i);
      end
    end
    idle_inputs();
    step();
    vectors++;
    if ({sysad_oe, evalid_l, eok_l} !== 3'b011) begin
      miscompares++;
      $display("FAIL br8_release oe/ev/eok got %b exp 011", {sysad_oe, evalid_l, eok_l});
    end
    step();
    vectors++;
    if ({eok_l, err_cnt - e0} !== {1'b0, 32'd0}) begin
      miscompares++;
      $display("FAIL br8_done eok=%b errs=%0d exp 0 0", eok_l, err_cnt - e0);
    end
    $display("block read 8 words: done");
  endtask

  task automatic test_read_err_sticky();
    pvalid_l = 1'b0; syscmd_in = 5'b00101; sysad_in = 32'h0000_3000;
    step();
    idle_inputs();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h100 + 32'(i);
      mem_rerr   = (i == 0);
      step();
      vectors++;
      if ({evalid_l, syscmd_out, sysad_out} !== {1'b0, (i < 3) ? 5'b11010 : 5'b10010, 32'h100 + 32'(i)}) begin
        miscompares++;
        $display("FAIL rerr_word%0d got ev=%b cmd=%b d=%h exp 0 %b %h", i, evalid_l, syscmd_out,
                 sysad_out, (i < 3) ? 5'b11010 : 5'b10010, 32'h100 + 32'(i));
      end
    end
    idle_inputs();
    step();
    step();
    $display("block read 4 words, err on word 0: done");
  endtask

  task automatic test_write_early_last();
    int e0 = err_cnt;
    pvalid_l = 1'b0; syscmd_in = 5'b01101; sysad_in = 32'h0000_4000;
    step();
    for (int i = 0; i < 3; i++) begin
      syscmd_in = (i == 2) ? 5'b10000 : 5'b11000;
      sysad_in  = 32'h4000 + 32'(i);
      step();
    end
    idle_inputs();
    vectors++;
    if ({cmd_err, mem_req} !== 2'b10) begin
      miscompares++;
      $display("FAIL early_last err/req got %b exp 10", {cmd_err, mem_req});
    end
    step();
    vectors++;
    if ({cmd_err, mem_req, eok_l, err_cnt - e0} !== {3'b000, 32'd1}) begin
      miscompares++;
      $display("FAIL early_last_idle err=%b req=%b eok=%b pulses=%0d exp 0 0 0 1", cmd_err, mem_req,
               eok_l, err_cnt - e0);
    end
    $display("block write early last marker: done");
  endtask

  task automatic test_write_timeout();
    int early = 0;
    pvalid_l = 1'b0; syscmd_in = 5'b01000; sysad_in = 32'h0000_5000;
    step();
    idle_inputs();
    for (int i = 1; i < 16; i++) begin
      step();
      if (cmd_err !== 1'b0) early++;
    end
    vectors++;
    if (early != 0) begin
      miscompares++;
      $display("FAIL wr_timeout_early got %0d early pulses exp 0", early);
    end
    step();
    vectors++;
    if ({cmd_err, mem_req} !== 2'b10) begin
      miscompares++;
      $display("FAIL wr_timeout err/req got %b exp 10", {cmd_err, mem_req});
    end
    step();
    $display("write data timeout: done");
  endtask

  task automatic test_read_timeout();
    int early = 0;
    pvalid_l = 1'b0; syscmd_in = 5'b00011; sysad_in = 32'h0000_6000;
    step();
    idle_inputs();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    for (int i = 1; i < 64; i++) begin
      step();
      if ({evalid_l, cmd_err} !== 2'b10) early++;
    end
    vectors++;
    if (early != 0) begin
      miscompares++;
      $display("FAIL rd_timeout_early got %0d early events exp 0", early);
    end
    step();
    vectors++;
    if ({evalid_l, cmd_err, syscmd_out, sysad_out} !== {2'b00, 5'b10010, 32'h0}) begin
      miscompares++;
      $display("FAIL rd_timeout_fill got ev=%b err=%b cmd=%b d=%h exp 0 0 10010 0", evalid_l, cmd_err,
               syscmd_out, sysad_out);
    end
    step();
    vectors++;
    if ({cmd_err, sysad_oe, evalid_l} !== 3'b101) begin
      miscompares++;
      $display("FAIL rd_timeout_err err/oe/ev got %b exp 101", {cmd_err, sysad_oe, evalid_l});
    end
    step();
    vectors++;
    if ({cmd_err, eok_l} !== 2'b00) begin
      miscompares++;
      $display("FAIL rd_timeout_idle err/eok got %b exp 00", {cmd_err, eok_l});
    end
    $display("single read backend timeout: done");
  endtask

  task automatic test_illegal();
    pvalid_l = 1'b0; syscmd_in = 5'b00111; sysad_in = 32'h0000_7000;
    step();
    vectors++;
    if ({cmd_err, eok_l, mem_req} !== 3'b100) begin
      miscompares++;
      $display("FAIL illegal_size err/eok/req got %b exp 100", {cmd_err, eok_l, mem_req});
    end
    syscmd_in = 5'b10000;
    step();
    vectors++;
    if (cmd_err !== 1'b1) begin
      miscompares++;
      $display("FAIL stray_data err got %b exp 1", cmd_err);
    end
    idle_inputs();
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    vectors++;
    if ({cmd_err, evalid_l} !== 2'b11) begin
      miscompares++;
      $display("FAIL stray_rvalid err/ev got %b exp 11", {cmd_err, evalid_l});
    end
    step();
    vectors++;
    if ({cmd_err, eok_l} !== 2'b00) begin
      miscompares++;
      $display("FAIL illegal_recover err/eok got %b exp 00", {cmd_err, eok_l});
    end
    $display("illegal size / stray data / stray rvalid: done");
  endtask

  task automatic test_reset_mid();
    // Reset while the backend request is outstanding.
    pvalid_l = 1'b0; syscmd_in = 5'b00000; sysad_in = 32'h0000_8000;
    step();
    idle_inputs();
    #2 reset_l = 1'b0;
    #1;
    vectors++;
    if ({mem_req, eok_l} !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_rmem req/eok got %b exp 01", {mem_req, eok_l});
    end
    step();
    reset_l = 1'b1;
    step();
    // Reset during word 3 of an 8-word read response.
    pvalid_l = 1'b0; syscmd_in = 5'b00110; sysad_in = 32'h0000_9000;
    step();
    idle_inputs();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h900 + 32'(i);
      step();
    end
    idle_inputs();
    vectors++;
    if ({sysad_oe, evalid_l, sysad_out} !== {2'b10, 32'h903}) begin
      miscompares++;
      $display("FAIL rst_pre oe/ev/d got %b %b %h exp 1 0 903", sysad_oe, evalid_l, sysad_out);
    end
    #2 reset_l = 1'b0;
    #1;
    vectors++;
    if ({sysad_oe, evalid_l, mem_req, eok_l} !== 4'b0101) begin
      miscompares++;
      $display("FAIL rst_rrsp oe/ev/req/eok got %b exp 0101", {sysad_oe, evalid_l, mem_req, eok_l});
    end
    step();
    reset_l = 1'b1;
    step();
    vectors++;
    if ({eok_l, sysad_oe} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_rrsp_release eok/oe got %b exp 00", {eok_l, sysad_oe});
    end
    // A fresh single read must see cleared counters and error state.
    pvalid_l = 1'b0; syscmd_in = 5'b00000; sysad_in = 32'h0000_A000;
    step();
    idle_inputs();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_005A;
    step();
    idle_inputs();
    vectors++;
    if ({evalid_l, syscmd_out, sysad_out} !== {1'b0, 5'b10000, 32'h5A}) begin
      miscompares++;
      $display("FAIL rst_after_read got ev=%b cmd=%b d=%h exp 0 10000 5a", evalid_l, syscmd_out, sysad_out);
    end
    step();
    step();
    $display("reset mid-transaction: done");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_block_write();
    test_block_read8();
    test_read_err_sticky();
    test_write_early_last();
    test_write_timeout();
    test_read_timeout();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
